// File: rtl/sdram_pkg.sv
// Shared encodings and defaults for the SDRAM port arbiter.
package sdram_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RA   = 2'd2,
    RD   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_CAP = 1'b1
  } owner_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sdram_arb_stats.sv
// Arbiter statistics (built only with SDRAM_ARB_STATS_EN): CPU wait cycles (saturating), capture words (wrapping).
module sdram_arb_stats (
  input  logic        clk_48,
  input  logic        irst,
  input  logic        stat_clr,
  input  logic        cpu_wait_inc,
  input  logic        cap_word_inc,
  output logic [15:0] stat_cpu_wait,
  output logic [31:0] stat_cap_words
);

  always_ff @(posedge clk_48 or posedge irst) begin
    if (irst) begin
      stat_cpu_wait  <= '0;
      stat_cap_words <= '0;
    end else if (stat_clr) begin
      stat_cpu_wait  <= '0;
      stat_cap_words <= '0;
    end else begin
      if (cpu_wait_inc && stat_cpu_wait != 16'hFFFF)
        stat_cpu_wait <= stat_cpu_wait + 16'd1;
      if (cap_word_inc)
        stat_cap_words <= stat_cap_words + 32'd1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// CPU / capture arbiter for the single SDRAM port: request -> m_*valid in 1 cycle, valids held until ready,
// capture bursts capped at BURST_MAX while the CPU waits. SDRAM_ARB_STATS_EN adds wait/word counters.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = 16
) (
  input  logic              clk_48,
  input  logic              irst,
  input  logic              en,
  input  logic              c_valid,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              k_valid,
  input  logic [ADDR_W-1:0] k_addr,
  input  logic [DATA_W-1:0] k_wdata,
  output logic              k_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid
`ifdef SDRAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_cpu_wait,
  output logic [31:0]       stat_cap_words
`endif
);

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  arb_state_t        state;
  owner_t            own;
  logic [7:0]        burst_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_fire, ar_fire, rd_fire, abort, cap_win, cpu_win;

  always_comb begin
    wr_fire = en && state == WR && m_wvalid && m_wready;
    ar_fire = en && state == RA && m_arvalid && m_arready;
    rd_fire = en && m_rvalid && (state == RD || ar_fire);
    abort   = !en && state != IDLE;
    cap_win = k_valid && !(c_valid && burst_cnt >= BURST_LIM);
    cpu_win = c_valid && !cap_win;
  end

  // Completion pulses line up with the controller handshake so the requester can present its next
  // request in the single IDLE cycle that follows.
  assign k_ready = wr_fire && own == OWN_CAP;
  assign c_done  = (wr_fire && own == OWN_CPU) || rd_fire || (abort && own == OWN_CPU);
  assign c_rdata = rd_fire ? m_rdata : (abort ? '0 : rdata_q);

  always_ff @(posedge clk_48 or posedge irst) begin
    if (irst) begin
      state     <= IDLE;
      own       <= OWN_CPU;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wvalid  <= 1'b0;
      m_arvalid <= 1'b0;
      rdata_q   <= '0;
      burst_cnt <= '0;
    end else begin
      if (!c_valid || c_done)
        burst_cnt <= '0;
      else if (k_ready)
        burst_cnt <= sat_inc8(burst_cnt);

      if (rd_fire)
        rdata_q <= m_rdata;
      else if (abort && own == OWN_CPU)
        rdata_q <= '0;

      if (abort) begin
        state     <= IDLE;
        m_wvalid  <= 1'b0;
        m_arvalid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (en) begin
            if (cap_win) begin
              own      <= OWN_CAP;
              m_addr   <= k_addr;
              m_wdata  <= k_wdata;
              m_wvalid <= 1'b1;
              state    <= WR;
            end else if (cpu_win) begin
              own    <= OWN_CPU;
              m_addr <= c_addr;
              if (c_we) begin
                m_wdata  <= c_wdata;
                m_wvalid <= 1'b1;
                state    <= WR;
              end else begin
                m_arvalid <= 1'b1;
                state     <= RA;
              end
            end
          end
          WR: if (wr_fire) begin
            m_wvalid <= 1'b0;
            state    <= IDLE;
          end
          RA: if (rd_fire) begin
            m_arvalid <= 1'b0;
            state     <= IDLE;
          end else if (ar_fire) begin
            m_arvalid <= 1'b0;
            state     <= RD;
          end
          RD: if (rd_fire) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  sdram_arb_stats u_stats (
    .clk_48         (clk_48),
    .irst           (irst),
    .stat_clr       (stat_clr),
    .cpu_wait_inc   (c_valid && !(state != IDLE && own == OWN_CPU)),
    .cap_word_inc   (k_ready),
    .stat_cpu_wait  (stat_cpu_wait),
    .stat_cap_words (stat_cap_words)
  );
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus a randomized run against a memory/scoreboard model.
module tb_sdram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BM = 4;

  logic          clk_48 = 1'b0;
  logic          irst;
  logic          en;
  logic          c_valid, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_done;
  logic [DW-1:0] c_rdata;
  logic          k_valid;
  logic [AW-1:0] k_addr;
  logic [DW-1:0] k_wdata;
  logic          k_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_wvalid, m_wready, m_arvalid, m_arready, m_rvalid;
  logic [DW-1:0] m_rdata;
`ifdef SDRAM_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_cpu_wait;
  logic [31:0]   stat_cap_words;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk_48 = ~clk_48;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk_48(clk_48), .irst(irst), .en(en),
    .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_done(c_done), .c_rdata(c_rdata),
    .k_valid(k_valid), .k_addr(k_addr), .k_wdata(k_wdata), .k_ready(k_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid)
`ifdef SDRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cpu_wait(stat_cpu_wait), .stat_cap_words(stat_cap_words)
`endif
  );

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; c_valid = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    k_valid = 1'b0; k_addr = '0; k_wdata = '0;
    m_wready = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    n_checks++;
    if ({m_wvalid, m_arvalid, c_done, k_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {m_wvalid, m_arvalid, c_done, k_ready});
    end
    n_checks++;
    if (m_addr !== '0 || m_wdata !== '0) begin
      n_fail++; $display("FAIL reset_m_bus: got addr %h data %h want 0/0", m_addr, m_wdata);
    end
    n_checks++;
    if (c_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", c_rdata);
    end
    irst = 1'b0;
    tick(); m_rvalid = 1'b1; m_rdata = 16'hFFFF; settle();
    n_checks++;
    if (c_done !== 1'b0 || c_rdata !== '0) begin
      n_fail++; $display("FAIL idle_rvalid_ignored: got done %b rdata %h want 0/0", c_done, c_rdata);
    end
    tick(); m_rvalid = 1'b0; settle();
  endtask

  task automatic test_cpu_write();
    int dones = 0;
    tick(); c_valid = 1'b1; c_we = 1'b1; c_addr = 24'h000010; c_wdata = 16'hBEEF; settle();
    n_checks++;
    if (m_wvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_early: got wvalid %b want 0", m_wvalid); end
    for (int i = 1; i <= 5; i++) begin
      tick(); m_wready = (i == 3); if (i == 4) c_valid = 1'b0; settle();
      if (c_done) dones++;
      if (i == 1) begin
        n_checks++;
        if (m_wvalid !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_wvalid: got %b want 1", m_wvalid); end
        n_checks++;
        if (m_addr !== 24'h000010 || m_wdata !== 16'hBEEF) begin
          n_fail++; $display("FAIL cpu_wr_bus: got %h/%h want 000010/beef", m_addr, m_wdata);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (c_done !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_done_hs: got %b want 1", c_done); end
      end
    end
    m_wready = 1'b0;
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL cpu_wr_done_count: got %0d want 1", dones); end
    n_checks++;
    if (m_wvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_release: got wvalid %b want 0", m_wvalid); end
  endtask

  task automatic test_cpu_read();
    int dones = 0;
    int krdy  = 0;
    tick(); c_valid = 1'b1; c_we = 1'b0; c_addr = 24'h0000A0; settle();
    for (int i = 1; i <= 9; i++) begin
      tick();
      m_arready = (i == 2);
      m_rvalid  = (i == 7 || i == 9);
      m_rdata   = (i == 7) ? 16'h1234 : 16'(i * 3 + 5);
      if (i == 8) c_valid = 1'b0;
      settle();
      if (c_done) dones++;
      if (k_ready) krdy++;
      if (i == 1) begin
        n_checks++;
        if (m_arvalid !== 1'b1 || m_addr !== 24'h0000A0) begin
          n_fail++; $display("FAIL cpu_rd_ar: got arvalid %b addr %h want 1/0000a0", m_arvalid, m_addr);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_ar_drop: got %b want 0", m_arvalid); end
      end
      if (i == 7) begin
        n_checks++;
        if (c_done !== 1'b1 || c_rdata !== 16'h1234) begin
          n_fail++; $display("FAIL cpu_rd_data: got done %b data %h want 1/1234", c_done, c_rdata);
        end
      end
    end
    m_rvalid = 1'b0; m_arready = 1'b0;
    n_checks++;
    if (dones != 1 || krdy != 0) begin
      n_fail++; $display("FAIL cpu_rd_pulses: got done %0d kready %0d want 1/0", dones, krdy);
    end
  endtask

  task automatic test_contention();
    int krdy_cpu = 0;
    int resumed  = 0;
    bit cpu_done = 0;
    bit prev_k   = 0;
    bit prev_c   = 0;
    tick(); k_valid = 1'b1; k_addr = 24'h000100; k_wdata = 16'($urandom); m_wready = 1'b1; settle();
    prev_k = k_ready;
    for (int cyc = 0; cyc < 200 && resumed < 2; cyc++) begin
      tick();
      if (prev_k) begin k_addr = k_addr + 24'd1; k_wdata = 16'($urandom); end
      if (cyc == 5) begin c_valid = 1'b1; c_we = 1'b1; c_addr = 24'h000055; c_wdata = 16'hC0DE; end
      if (prev_c) c_valid = 1'b0;
      settle();
      if (k_ready && c_valid && !cpu_done) krdy_cpu++;
      if (k_ready && cpu_done) resumed++;
      if (c_done) cpu_done = 1;
      prev_k = k_ready; prev_c = c_done;
    end
    tick(); k_valid = 1'b0; c_valid = 1'b0; m_wready = 1'b0; settle();
    n_checks++;
    if (!cpu_done) begin n_fail++; $display("FAIL cont_cpu_served: got 0 want 1"); end
    n_checks++;
    if (krdy_cpu != BM) begin n_fail++; $display("FAIL cont_burst: got %0d words want %0d", krdy_cpu, BM); end
    n_checks++;
    if (resumed != 2) begin n_fail++; $display("FAIL cont_resume: got %0d words want 2", resumed); end
  endtask

  task automatic test_simul();
    int n_cap = 2;
    int kw = 0;
    int krdy_before = 0;
    bit got_done = 0;
    bit prev_k = 0;
    tick();
    k_valid = 1'b1; k_addr = 24'h000321; k_wdata = 16'h0A0A;
    c_valid = 1'b1; c_we = 1'b1; c_addr = 24'h000777; c_wdata = 16'h7777; m_wready = 1'b0;
    settle();
    tick(); m_wready = 1'b1; settle();
    n_checks++;
    if (m_wvalid !== 1'b1 || m_addr !== 24'h000321) begin
      n_fail++; $display("FAIL simul_first_cap: got wvalid %b addr %h want 1/000321", m_wvalid, m_addr);
    end
    if (k_ready) krdy_before++;
    prev_k = k_ready;
    for (int i = 0; i < 50 && !got_done; i++) begin
      tick();
      if (prev_k) begin
        kw++;
        if (kw < n_cap) begin k_addr = 24'h000322; k_wdata = 16'h0B0B; end
        else k_valid = 1'b0;
      end
      settle();
      if (k_ready && !got_done) krdy_before++;
      if (c_done) got_done = 1;
      prev_k = k_ready;
    end
    tick(); c_valid = 1'b0; k_valid = 1'b0; m_wready = 1'b0; settle();
    n_checks++;
    if (!got_done || krdy_before != ((n_cap < BM) ? n_cap : BM)) begin
      n_fail++; $display("FAIL simul_cpu_bound: got done %0d words %0d want 1/%0d", got_done, krdy_before, (n_cap < BM) ? n_cap : BM);
    end
  endtask

  task automatic test_en_drop();
    int leaks = 0;
    tick(); c_valid = 1'b1; c_we = 1'b0; c_addr = 24'h0000B0; settle();
    tick(); m_arready = 1'b1; settle();
    tick(); m_arready = 1'b0; k_valid = 1'b1; k_addr = 24'h000999; k_wdata = 16'h9999; settle();
    tick(); settle();
    n_checks++;
    if (c_done !== 1'b0) begin n_fail++; $display("FAIL endrop_stuck: got done %b want 0", c_done); end
    tick(); en = 1'b0; settle();
    n_checks++;
    if (c_done !== 1'b1 || c_rdata !== '0) begin
      n_fail++; $display("FAIL endrop_done: got done %b rdata %h want 1/0000", c_done, c_rdata);
    end
    tick(); c_valid = 1'b0; settle();
    n_checks++;
    if (m_arvalid !== 1'b0 || c_done !== 1'b0) begin
      n_fail++; $display("FAIL endrop_idle: got arvalid %b done %b want 0/0", m_arvalid, c_done);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      if (m_wvalid || m_arvalid || k_ready) leaks++;
    end
    n_checks++;
    if (leaks != 0) begin n_fail++; $display("FAIL endrop_no_grant: got %0d grant cycles want 0", leaks); end
    tick(); en = 1'b1; settle();
    tick(); settle();
    n_checks++;
    if (m_wvalid !== 1'b1 || m_addr !== 24'h000999) begin
      n_fail++; $display("FAIL endrop_regrant: got wvalid %b addr %h want 1/000999", m_wvalid, m_addr);
    end
    tick(); m_wready = 1'b1; settle();
    n_checks++;
    if (k_ready !== 1'b1) begin n_fail++; $display("FAIL endrop_kready: got %b want 1", k_ready); end
    tick(); k_valid = 1'b0; m_wready = 1'b0; settle();
  endtask

  task automatic test_reset_mid_wr();
    tick(); k_valid = 1'b1; k_addr = 24'h000ABC; k_wdata = 16'h1357; m_wready = 1'b0; settle();
    tick(); settle();
    n_checks++;
    if (m_wvalid !== 1'b1) begin n_fail++; $display("FAIL rstwr_setup: got wvalid %b want 1", m_wvalid); end
    #3; irst = 1'b1; m_wready = 1'b1; #1;
    n_checks++;
    if (m_wvalid !== 1'b0 || k_ready !== 1'b0 || c_done !== 1'b0) begin
      n_fail++; $display("FAIL rstwr_async: got wvalid %b kready %b done %b want 0/0/0", m_wvalid, k_ready, c_done);
    end
    tick(); irst = 1'b0; m_wready = 1'b0; settle();
    tick(); settle();
    n_checks++;
    if (m_wvalid !== 1'b1 || m_addr !== 24'h000ABC || m_wdata !== 16'h1357) begin
      n_fail++; $display("FAIL rstwr_regrant: got %b %h %h want 1 000abc 1357", m_wvalid, m_addr, m_wdata);
    end
    tick(); m_wready = 1'b1; settle();
    n_checks++;
    if (k_ready !== 1'b1) begin n_fail++; $display("FAIL rstwr_kready: got %b want 1", k_ready); end
    tick(); k_valid = 1'b0; m_wready = 1'b0; settle();
  endtask

  task automatic test_random();
    logic [15:0] ctrl_mem [8];
    logic [15:0] ref_mem  [8];
    logic [2:0]  rd_addr = '0;
    int rd_cnt = -1;
    int k_wait = 0, c_wait = 0, max_wait = 0;
    int kwords = 0, cops = 0, krdy_pend = 0;
    bit prev_k = 0, prev_c = 0;
    for (int i = 0; i < 8; i++) begin
      ctrl_mem[i] = 16'hA500 | 16'(i);
      ref_mem[i]  = 16'hA500 | 16'(i);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (prev_k) k_valid = 1'b0;
      if (prev_c) c_valid = 1'b0;
      if (!k_valid && $urandom_range(0, 99) < 60) begin
        k_valid = 1'b1; k_addr = {21'd0, 3'($urandom)}; k_wdata = 16'($urandom); k_wait = 0;
      end
      if (!c_valid && $urandom_range(0, 99) < 8) begin
        c_valid = 1'b1; c_we = 1'($urandom_range(0, 1)); c_addr = {21'd0, 3'($urandom)};
        c_wdata = 16'($urandom); c_wait = 0; krdy_pend = 0;
      end
      m_wready  = ($urandom_range(0, 99) < 50);
      m_arready = ($urandom_range(0, 99) < 40);
      m_rvalid  = 1'b0;
      if (rd_cnt == 0) begin
        m_rvalid = 1'b1; m_rdata = ctrl_mem[rd_addr];
      end else if (m_arvalid && m_arready && $urandom_range(0, 99) < 30) begin
        m_rvalid = 1'b1; m_rdata = ctrl_mem[m_addr[2:0]];
      end
      settle();
      if (m_wvalid && m_wready) ctrl_mem[m_addr[2:0]] = m_wdata;
      if (m_rvalid) rd_cnt = -1;
      else if (rd_cnt > 0) rd_cnt--;
      if (m_arvalid && m_arready && !m_rvalid) begin rd_addr = m_addr[2:0]; rd_cnt = $urandom_range(0, 3); end
      if (k_ready) begin
        n_checks++;
        if (!(m_wvalid && m_wready) || m_addr !== k_addr || m_wdata !== k_wdata) begin
          n_fail++; $display("FAIL rnd_cap_word: got addr %h data %h want %h %h", m_addr, m_wdata, k_addr, k_wdata);
        end
        ref_mem[k_addr[2:0]] = k_wdata;
        kwords++;
        if (c_valid) krdy_pend++;
      end
      if (c_done) begin
        n_checks++;
        if (c_we) begin
          if (!(m_wvalid && m_wready) || m_addr !== c_addr || m_wdata !== c_wdata) begin
            n_fail++; $display("FAIL rnd_cpu_write: got addr %h data %h want %h %h", m_addr, m_wdata, c_addr, c_wdata);
          end
          ref_mem[c_addr[2:0]] = c_wdata;
        end else if (c_rdata !== ref_mem[c_addr[2:0]]) begin
          n_fail++; $display("FAIL rnd_cpu_read: addr %h got %h want %h", c_addr, c_rdata, ref_mem[c_addr[2:0]]);
        end
        n_checks++;
        if (krdy_pend > BM) begin
          n_fail++; $display("FAIL rnd_cpu_latency: got %0d capture words while pending want <= %0d", krdy_pend, BM);
        end
        cops++;
      end
      if (k_valid && !k_ready) k_wait++;
      if (c_valid && !c_done) c_wait++;
      if (k_wait > max_wait) max_wait = k_wait;
      if (c_wait > max_wait) max_wait = c_wait;
      prev_k = k_ready; prev_c = c_done;
    end
    n_checks++;
    if (max_wait > 300) begin n_fail++; $display("FAIL rnd_timeout: got wait %0d want <= 300", max_wait); end
    n_checks++;
    if (kwords < 50 || cops < 20) begin
      n_fail++; $display("FAIL rnd_traffic: got %0d cap %0d cpu want >= 50/20", kwords, cops);
    end
    irst = 1'b1;
    idle_inputs();
    tick();
    irst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_contention();
    test_simul();
    test_en_drop();
    test_reset_mid_wr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
